// File: rtl/ws_seq_pkg.sv
// Shared types and constants for the weight-stationary array sequencer.
// The perf counters are built only when WS_SEQ_PERF_CNT_EN is defined; this package provides their saturating helper.
package ws_seq_pkg;

    localparam int MAX_PIPE_LAT = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } ws_seq_state_t;

    // Saturating 32-bit increment used by the perf counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/ws_seq_valid_pipe.sv
// Fixed-latency delay line for the array result-valid strobe, with an empty flag
// that tells the sequencer when every issued operand has emerged.
import ws_seq_pkg::*;

module ws_seq_valid_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic out_valid,
    output logic empty
);

    logic [LAT-1:0] pipe_r;

    // Shift one slot per cycle; slot LAT-1 is the strobe seen by the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_r <= {LAT{1'b0}};
        end else begin
            pipe_r[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Output strobe comes straight from the last register stage.
    always_comb begin
        out_valid = pipe_r[LAT-1];
        empty     = (pipe_r == {LAT{1'b0}});
    end

endmodule

// File: rtl/ws_array_sequencer.sv
// Job sequencer for a weight-stationary systolic array: loads ROWS weight rows,
// streams num_vec B vectors, drains the result pipe, then pulses done.
// Optional perf counters are enabled with the WS_SEQ_PERF_CNT_EN macro.
import ws_seq_pkg::*;

module ws_array_sequencer #(
    parameter int W        = 8,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int VEC_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VEC_W-1:0]     num_vec,
    output logic                 busy,
    output logic                 done,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [COLS*W-1:0]    w_data,
    output logic [COLS*W-1:0]    arr_a_in,
    output logic                 arr_stationary,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ROWS*W-1:0]    b_data,
    output logic [ROWS*W-1:0]    arr_b_in,
    output logic                 c_valid
`ifdef WS_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_busy_cyc,
    output logic [31:0]          perf_stall_cyc
`endif
);

    localparam int CNT_W   = $clog2(ROWS + 1);
    localparam int EFF_LAT = (PIPE_LAT > MAX_PIPE_LAT) ? MAX_PIPE_LAT :
                             ((PIPE_LAT < 1) ? 1 : PIPE_LAT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ROWS);
    localparam logic [VEC_W-1:0] ONE_VEC   = VEC_W'(1);

    ws_seq_state_t      state_r;
    logic [CNT_W-1:0]   load_cnt_r;
    logic [VEC_W-1:0]   vec_left_r;
    logic               w_fire_s;
    logic               b_fire_s;
    logic               pipe_empty_s;

    // Handshake fires; gated by rst so the array sees nothing during reset.
    always_comb begin
        w_fire_s = w_ready & w_valid & ~rst;
        b_fire_s = b_ready & b_valid & ~rst;
    end

    // Array operands are presented in the accepting cycle and zeroed otherwise.
    always_comb begin
        arr_stationary = 1'b0;
        arr_a_in       = {(COLS*W){1'b0}};
        arr_b_in       = {(ROWS*W){1'b0}};
        if (w_fire_s) begin
            arr_stationary = 1'b1;
            arr_a_in       = w_data;
        end else begin
            arr_stationary = 1'b0;
            arr_a_in       = {(COLS*W){1'b0}};
        end
        if (b_fire_s) begin
            arr_b_in = b_data;
        end else begin
            arr_b_in = {(ROWS*W){1'b0}};
        end
    end

    ws_seq_valid_pipe #(
        .LAT (EFF_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_fire_s),
        .out_valid (c_valid),
        .empty     (pipe_empty_s)
    );

    // Job FSM; readies, busy and done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            load_cnt_r <= {CNT_W{1'b0}};
            vec_left_r <= {VEC_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            w_ready    <= 1'b0;
            b_ready    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= LOAD;
                        vec_left_r <= num_vec;
                        load_cnt_r <= {CNT_W{1'b0}};
                        busy       <= 1'b1;
                        w_ready    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_fire_s) begin
                        if (load_cnt_r == LAST_BEAT) begin
                            load_cnt_r <= FULL_CNT;
                            w_ready    <= 1'b0;
                            if (vec_left_r == {VEC_W{1'b0}}) begin
                                state_r <= DONE;
                                done    <= 1'b1;
                            end else begin
                                state_r <= COMPUTE;
                                b_ready <= 1'b1;
                            end
                        end else begin
                            load_cnt_r <= load_cnt_r + CNT_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (b_fire_s) begin
                        vec_left_r <= vec_left_r - ONE_VEC;
                        if (vec_left_r == ONE_VEC) begin
                            b_ready <= 1'b0;
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty_s) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    w_ready <= 1'b0;
                    b_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef WS_SEQ_PERF_CNT_EN
    logic stall_s;

    // A stall is an open ready with nothing offered on the matching stream.
    always_comb begin
        stall_s = (w_ready & ~w_valid) | (b_ready & ~b_valid);
    end

    // Saturating perf counters, restarted by each accepted job.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cyc  <= 32'd0;
            perf_stall_cyc <= 32'd0;
        end else if ((state_r == IDLE) && start) begin
            perf_busy_cyc  <= 32'd0;
            perf_stall_cyc <= 32'd0;
        end else begin
            if (busy) begin
                perf_busy_cyc <= sat_inc32(perf_busy_cyc);
            end
            if (stall_s) begin
                perf_stall_cyc <= sat_inc32(perf_stall_cyc);
            end
        end
    end
`endif

endmodule

// File: doc/ws_array_sequencer.md
WS_ARRAY_SEQUENCER -- requirements
Module: ws_array_sequencer

Interface
REQ-001 Parameter W, default 8, operand width in bits.
REQ-002 Parameter ROWS, default 4, PE rows; also the weight-chain depth.
REQ-003 Parameter COLS, default 4, PE columns.
REQ-004 Parameter VEC_W, default 8, width of num_vec.
REQ-005 Parameter PIPE_LAT, default 2, array compute latency in cycles (1..8).
REQ-006 Ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 start in 1, one-cycle job request; num_vec in VEC_W, number of B vectors in the job.
REQ-008 busy out 1, job in progress; done out 1, one-cycle end-of-job pulse.
REQ-009 w_valid in 1, w_ready out 1, w_data in COLS*W: weight-row stream.
REQ-010 arr_a_in out COLS*W, arr_stationary out 1: weight-chain data and shift enable.
REQ-011 b_valid in 1, b_ready out 1, b_data in ROWS*W: B-vector stream.
REQ-012 arr_b_in out ROWS*W, c_valid out 1: array operand and result-valid strobe.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN, DONE.
REQ-014 IDLE -> LOAD on start; latch num_vec into vec_left and clear load_cnt.
REQ-015 start while not in IDLE SHALL be ignored.
REQ-016 LOAD: w_ready=1; on each w_valid&w_ready, arr_stationary=1 and arr_a_in=w_data in the same cycle, load_cnt++.
REQ-017 LOAD -> COMPUTE after the ROWS-th weight beat; if latched num_vec==0, LOAD -> DONE directly.
REQ-018 Outside a weight beat, arr_stationary=0 and arr_a_in=0, so stationary weights are held.
REQ-019 COMPUTE: b_ready=1 while vec_left>0; on each b fire, arr_b_in=b_data and vec_left--; otherwise arr_b_in=0.
REQ-020 COMPUTE -> DRAIN in the cycle after the last b fire.
REQ-021 c_valid SHALL assert exactly PIPE_LAT cycles after each b fire, one pulse per fire, preserving gaps.
REQ-022 DRAIN -> DONE when the valid pipe is empty; DONE asserts done for one cycle, then goes to IDLE.
REQ-023 busy=1 in every state except IDLE.
REQ-024 b_valid during LOAD and w_valid during COMPUTE SHALL be ignored (the corresponding ready is 0).
REQ-025 load_cnt and vec_left SHALL never wrap; the maximum num_vec (2^VEC_W-1) SHALL be supported.

Reset
REQ-026 rst SHALL force state IDLE, counters 0 and the valid pipe cleared.
REQ-027 During reset, all outputs SHALL be 0: busy, done, w_ready, b_ready, arr_stationary, arr_a_in, arr_b_in, c_valid.
REQ-028 rst mid-job SHALL abort without a done pulse.
REQ-029 After rst, the next start SHALL begin a fresh LOAD of ROWS beats.

Configuration
REQ-030 Macro WS_SEQ_PERF_CNT_EN, when defined, SHALL add outputs perf_busy_cyc[31:0] and perf_stall_cyc[31:0].
REQ-031 perf_busy_cyc SHALL count busy cycles.
REQ-032 perf_stall_cyc SHALL count cycles in which the ready is high and the matching valid is low (w_ready&!w_valid or b_ready&!b_valid).
REQ-033 Both counters SHALL clear on rst and on accepted start, and saturate at all-ones.
REQ-034 With the macro undefined, these ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-035 Package ws_seq_pkg SHALL hold the state enum typedef and constant MAX_PIPE_LAT=8.
REQ-036 Sub-module ws_seq_valid_pipe SHALL implement the PIPE_LAT-deep c_valid delay line with an empty flag.

Verification
REQ-037 ROWS=4, num_vec=3, all valids high: 4 arr_stationary beats, then 3 b fires, c_valid at fire+2, one done pulse.
REQ-038 num_vec=0: 4 weight beats, then done with no b_ready or c_valid.
REQ-039 b_valid toggling 1,0,1,0,1, num_vec=3: c_valid pattern matches the fire pattern delayed by PIPE_LAT.
REQ-040 start pulsed mid-COMPUTE: ignored; vec_left and done timing are unchanged.
REQ-041 rst after the 2nd weight beat: all outputs 0, no done; a new start needs 4 fresh weight beats.
REQ-042 WS_SEQ_PERF_CNT_EN defined, w_valid low for 3 LOAD cycles: perf_stall_cyc=3 at done.
